// File: rtl/or_nway_pipe.sv
// or_nway_pipe: pipelined N-way OR reduction with valid/ready handshake and optional per-frame accumulate
module or_nway_pipe #(
    parameter int WIDTH         = 16,
    parameter int LVL_PER_STAGE = 2,
    parameter int ACCUM         = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any,
    output logic             out_zero
);
    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;
    localparam int S = (L + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

    // n pairwise-OR levels; bits above the surviving span are forced to zero
    function automatic logic [P-1:0] fold(input logic [P-1:0] x, input int n);
        logic [P-1:0] y, z;
        y = x;
        for (int k = 0; k < n; k++) begin
            z = '0;
            for (int i = 0; i < (P >> (k + 1)); i++) z[i] = y[2*i] | y[2*i+1];
            y = z;
        end
        return y;
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign out_zero = out_valid & ~out_any;

    for (genvar s = 0; s < S - 1; s++) begin : g
        logic [P-1:0] x, q;
        logic         xv, xl, qv, ql;
        if (s == 0) begin : h
            assign x  = P'(in_data);
            assign xv = in_valid;
            assign xl = in_last;
        end else begin : h
            assign x  = g[s-1].q;
            assign xv = g[s-1].qv;
            assign xl = g[s-1].ql;
        end
        always_ff @(posedge clk)
            if (reset) qv <= 1'b0;
            else if (adv) begin
                q  <= fold(x, LVL_PER_STAGE);
                qv <= xv;
                ql <= xl;
            end
    end

    logic [P-1:0] fx;
    logic         fv, fl;
    if (S == 1) begin : f
        assign fx = P'(in_data);
        assign fv = in_valid;
        assign fl = in_last;
    end else begin : f
        assign fx = g[S-2].q;
        assign fv = g[S-2].qv;
        assign fl = g[S-2].ql;
    end

    // final stage folds its remaining levels and owns the frame accumulator
    logic acc, bo, close;
    assign bo    = |fx;
    assign close = fv & ((ACCUM == 0) | fl);

    always_ff @(posedge clk)
        if (reset) begin
            out_valid <= 1'b0;
            out_any   <= 1'b0;
            acc       <= 1'b0;
        end else if (adv) begin
            out_valid <= close;
            out_any   <= close & (acc | bo);
            acc       <= ~close & (acc | (fv & bo));
        end
endmodule

// File: tb/tb_or_nway_pipe.sv
// tb_or_nway_pipe: directed and randomized checks of or_nway_pipe in three configurations
module tb_or_nway_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_data, b_data;
    logic [8:0]  c_data;
    logic a_valid, a_last, a_ready, a_oready, a_ov, a_any, a_zero;
    logic b_valid, b_last, b_ready, b_oready, b_ov, b_any, b_zero;
    logic c_valid, c_last, c_ready, c_oready, c_ov, c_any, c_zero;
    int vectors = 0;
    int miscompares = 0;

    or_nway_pipe #(.WIDTH(16), .LVL_PER_STAGE(2), .ACCUM(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(a_ready), .out_valid(a_ov), .out_ready(a_oready), .out_any(a_any), .out_zero(a_zero));
    or_nway_pipe #(.WIDTH(16), .LVL_PER_STAGE(2), .ACCUM(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_ready(b_ready), .out_valid(b_ov), .out_ready(b_oready), .out_any(b_any), .out_zero(b_zero));
    or_nway_pipe #(.WIDTH(9), .LVL_PER_STAGE(1), .ACCUM(0)) dut_c (
        .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
        .in_ready(c_ready), .out_valid(c_ov), .out_ready(c_oready), .out_any(c_any), .out_zero(c_zero));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // zero, single bit anywhere, all ones, or a random word, limited to w bits
    function automatic logic [15:0] gen(int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        case ($urandom_range(3))
            0:       return 16'h0000;
            1:       return 16'(32'd1 << $urandom_range(w - 1));
            2:       return m;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        a_valid = 1'b1; a_data = 16'hFFFF;
        b_valid = 1'b1; b_data = 16'hFFFF; b_last = 1'b1;
        c_valid = 1'b1; c_data = 9'h1FF;
        repeat (3) begin
            tick;
            @(negedge clk);
            vectors++;
            if ({a_ov, a_any, a_zero, b_ov, b_any, b_zero, c_ov, c_any, c_zero} !== 9'b0) begin
                miscompares++;
                $display("FAIL reset_outputs got %b want 000000000",
                         {a_ov, a_any, a_zero, b_ov, b_any, b_zero, c_ov, c_any, c_zero});
            end
        end
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        b_last = 1'b0;
        vectors++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 111", {a_ready, b_ready, c_ready});
        end
        repeat (6) begin
            tick;
            @(negedge clk);
            vectors++;
            if ({a_ov, b_ov, c_ov} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_no_result got %b want 000", {a_ov, b_ov, c_ov});
            end
        end
    endtask

    task automatic test_latency;
        logic [15:0] beats [4];
        logic ev, ea;
        beats = '{16'h0000, 16'h8000, 16'h0001, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            tick;
            a_valid = (k < 4);
            a_data  = (k < 4) ? beats[k] : 16'h0000;
            @(negedge clk);
            ev = (k >= 2 && k < 6);
            ea = ev && (beats[ev ? k - 2 : 0] != 16'h0000);
            vectors++;
            if ({a_ov, a_any, a_zero, a_ready} !== {ev, ea, ev & ~ea, 1'b1}) begin
                miscompares++;
                $display("FAIL latency cycle %0d got v/any/zero/rdy=%b want %b", k,
                         {a_ov, a_any, a_zero, a_ready}, {ev, ea, ev & ~ea, 1'b1});
            end
        end
    endtask

    task automatic test_odd_width;
        logic [8:0] beats [2];
        logic ev, ea;
        beats = '{9'h100, 9'h000};
        for (int k = 0; k < 9; k++) begin
            tick;
            c_valid = (k < 2);
            c_data  = (k < 2) ? beats[k] : 9'h000;
            @(negedge clk);
            ev = (k >= 4 && k < 6);
            ea = ev && (beats[ev ? k - 4 : 0] != 9'h000);
            vectors++;
            if ({c_ov, c_any, c_zero} !== {ev, ea, ev & ~ea}) begin
                miscompares++;
                $display("FAIL odd_width cycle %0d got v/any/zero=%b want %b", k,
                         {c_ov, c_any, c_zero}, {ev, ea, ev & ~ea});
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] bq [3];
        logic ev, ea, er;
        int p = 0;
        bq = '{16'h0010, 16'h0000, 16'h2000};
        for (int k = 0; k < 10; k++) begin
            tick;
            a_oready = !(k >= 2 && k <= 4);
            a_valid  = (p < 3);
            a_data   = (p < 3) ? bq[p] : 16'h0000;
            @(negedge clk);
            er = !(k >= 2 && k <= 4);
            ev = (k >= 2 && k <= 7);
            ea = ev && (k != 6);
            vectors++;
            if ({a_ov, a_any, a_zero, a_ready} !== {ev, ea, ev & ~ea, er}) begin
                miscompares++;
                $display("FAIL backpressure cycle %0d got v/any/zero/rdy=%b want %b", k,
                         {a_ov, a_any, a_zero, a_ready}, {ev, ea, ev & ~ea, er});
            end
            if (a_valid && a_ready) p++;
        end
        vectors++;
        if (p != 3) begin
            miscompares++;
            $display("FAIL backpressure_accepted got %0d want 3", p);
        end
    endtask

    task automatic test_accum;
        logic [15:0] d [4];
        logic [3:0] l;
        logic ev, ea;
        d = '{16'h0000, 16'h0400, 16'h0000, 16'h0000};
        l = 4'b1100;
        for (int k = 0; k < 9; k++) begin
            tick;
            b_valid = (k < 4);
            b_data  = (k < 4) ? d[k] : 16'h0000;
            b_last  = (k < 4) ? l[k] : 1'b0;
            @(negedge clk);
            ev = (k == 4 || k == 5);
            ea = (k == 4);
            vectors++;
            if ({b_ov, b_any, b_zero} !== {ev, ea, ev & ~ea}) begin
                miscompares++;
                $display("FAIL accum cycle %0d got v/any/zero=%b want %b", k,
                         {b_ov, b_any, b_zero}, {ev, ea, ev & ~ea});
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic ev;
        for (int k = 0; k < 9; k++) begin
            tick;
            reset   = (k == 2);
            b_valid = (k == 0 || k == 1 || k == 3);
            b_data  = (k == 0) ? 16'hFFFF : 16'h0000;
            b_last  = (k == 3);
            @(negedge clk);
            ev = (k == 5);
            vectors++;
            if ({b_ov, b_any, b_zero} !== {ev, 1'b0, ev}) begin
                miscompares++;
                $display("FAIL reset_midframe cycle %0d got v/any/zero=%b want %b", k,
                         {b_ov, b_any, b_zero}, {ev, 1'b0, ev});
            end
        end
    endtask

    task automatic test_random_beats;
        bit qa[$], qc[$];
        logic sa = 1'b0, sc = 1'b0, pa = 1'b0, pc = 1'b0, e;
        logic [15:0] t;
        for (int n = 0; n < 460; n++) begin
            tick;
            if (n < 400) begin
                a_valid = 1'($urandom_range(1)); a_data = gen(16); a_oready = ($urandom_range(3) != 0);
                c_valid = 1'($urandom_range(1)); t = gen(9); c_data = t[8:0]; c_oready = ($urandom_range(3) != 0);
            end else begin
                a_valid = 1'b0; a_oready = 1'b1;
                c_valid = 1'b0; c_oready = 1'b1;
            end
            @(negedge clk);
            vectors += 2;
            if (a_zero !== (a_ov & ~a_any) || a_ready !== (~a_ov | a_oready)) begin
                miscompares++;
                $display("FAIL rand_a_flags cycle %0d got zero/rdy=%b%b want %b%b", n,
                         a_zero, a_ready, a_ov & ~a_any, ~a_ov | a_oready);
            end
            if (c_zero !== (c_ov & ~c_any) || c_ready !== (~c_ov | c_oready)) begin
                miscompares++;
                $display("FAIL rand_c_flags cycle %0d got zero/rdy=%b%b want %b%b", n,
                         c_zero, c_ready, c_ov & ~c_any, ~c_ov | c_oready);
            end
            if (sa) begin
                vectors++;
                if (a_ov !== 1'b1 || a_any !== pa) begin
                    miscompares++;
                    $display("FAIL rand_a_hold cycle %0d got v/any=%b%b want 1%b", n, a_ov, a_any, pa);
                end
            end
            if (sc) begin
                vectors++;
                if (c_ov !== 1'b1 || c_any !== pc) begin
                    miscompares++;
                    $display("FAIL rand_c_hold cycle %0d got v/any=%b%b want 1%b", n, c_ov, c_any, pc);
                end
            end
            if (a_ov && a_oready) begin
                vectors++;
                e = (qa.size() != 0) ? qa.pop_front() : 1'bx;
                if (a_any !== e) begin
                    miscompares++;
                    $display("FAIL rand_a_data cycle %0d got %b want %b", n, a_any, e);
                end
            end
            if (c_ov && c_oready) begin
                vectors++;
                e = (qc.size() != 0) ? qc.pop_front() : 1'bx;
                if (c_any !== e) begin
                    miscompares++;
                    $display("FAIL rand_c_data cycle %0d got %b want %b", n, c_any, e);
                end
            end
            if (a_valid && a_ready) qa.push_back(a_data != 16'h0000);
            if (c_valid && c_ready) qc.push_back(c_data != 9'h000);
            sa = a_ov & ~a_oready; pa = a_any;
            sc = c_ov & ~c_oready; pc = c_any;
        end
        vectors++;
        if (qa.size() != 0 || qc.size() != 0) begin
            miscompares++;
            $display("FAIL rand_beats_leftover got %0d/%0d pending want 0/0", qa.size(), qc.size());
        end
    endtask

    task automatic test_random_frames;
        bit qb[$];
        logic sb = 1'b0, pb = 1'b0, accm = 1'b0, closed = 1'b0, e;
        for (int n = 0; n < 460; n++) begin
            tick;
            if (n < 400) begin
                b_valid = 1'($urandom_range(1)); b_data = gen(16);
                b_last = ($urandom_range(2) == 0); b_oready = ($urandom_range(3) != 0);
            end else begin
                b_valid = !closed; b_data = 16'h0000; b_last = 1'b1; b_oready = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (b_zero !== (b_ov & ~b_any) || b_ready !== (~b_ov | b_oready)) begin
                miscompares++;
                $display("FAIL rand_b_flags cycle %0d got zero/rdy=%b%b want %b%b", n,
                         b_zero, b_ready, b_ov & ~b_any, ~b_ov | b_oready);
            end
            if (sb) begin
                vectors++;
                if (b_ov !== 1'b1 || b_any !== pb) begin
                    miscompares++;
                    $display("FAIL rand_b_hold cycle %0d got v/any=%b%b want 1%b", n, b_ov, b_any, pb);
                end
            end
            if (b_ov && b_oready) begin
                vectors++;
                e = (qb.size() != 0) ? qb.pop_front() : 1'bx;
                if (b_any !== e) begin
                    miscompares++;
                    $display("FAIL rand_b_frame cycle %0d got %b want %b", n, b_any, e);
                end
            end
            if (b_valid && b_ready) begin
                accm = accm | (b_data != 16'h0000);
                if (b_last) begin
                    qb.push_back(accm);
                    accm = 1'b0;
                end
                if (n >= 400) closed = 1'b1;
            end
            sb = b_ov & ~b_oready; pb = b_any;
        end
        vectors++;
        if (qb.size() != 0 || !closed) begin
            miscompares++;
            $display("FAIL rand_frames_leftover got %0d pending closed=%b want 0 closed=1", qb.size(), closed);
        end
    endtask

    initial begin
        a_valid = 1'b0; a_last = 1'b0; a_data = '0; a_oready = 1'b1;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_oready = 1'b1;
        c_valid = 1'b0; c_last = 1'b0; c_data = '0; c_oready = 1'b1;
        test_reset;
        test_latency;
        test_odd_width;
        test_backpressure;
        test_accum;
        test_reset_midframe;
        test_random_beats;
        test_random_frames;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
